// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks a register range through a combinational read port and streams it over valid/ready.
// Define REGFILE_DUMP_CHECKSUM_EN to add a running checksum output of the accepted words.
module regfile_dump_reader #(
  parameter int REG_NUM_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [REG_NUM_WIDTH-1:0] first_reg,
  input  logic [REG_NUM_WIDTH-1:0] last_reg,
  input  logic                     abort,
  output logic [REG_NUM_WIDTH-1:0] rf_rd_num,
  input  logic [DATA_WIDTH-1:0]    rf_rd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [REG_NUM_WIDTH-1:0] out_num,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
`ifdef REGFILE_DUMP_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0]    checksum
`endif
);
  typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;
  state_t state, state_nx;
  logic [REG_NUM_WIDTH-1:0] cur, last_r, nxt;
  logic hs;
  assign hs  = out_valid && out_ready;
  assign nxt = cur + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = abort ? IDLE :
               state == IDLE  ? (start ? FETCH : IDLE) :
               state == FETCH ? STREAM :
               (hs && out_last) ? IDLE : STREAM;
  // STREAM presents cur+1 so the next word is ready at the handshake edge
  always_comb begin
    rf_rd_num = state == FETCH ? cur : state == STREAM ? nxt : '0;
    busy      = state != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= '0;
      last_r    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_num   <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else if (state == IDLE && start) begin
        cur    <= first_reg;
        last_r <= last_reg;
      end else if (state == FETCH) begin
        out_data  <= rf_rd_data;
        out_num   <= cur;
        out_last  <= cur == last_r;
        out_valid <= 1'b1;
      end else if (state == STREAM && hs && out_last) begin
        out_valid <= 1'b0;
        done      <= 1'b1;
      end else if (state == STREAM && hs) begin
        out_data <= rf_rd_data;
        out_num  <= nxt;
        out_last <= nxt == last_r;
        cur      <= nxt;
      end
    end
  end
`ifdef REGFILE_DUMP_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) checksum <= '0;
    else if (abort || (state == IDLE && start)) checksum <= '0;
    else if (state == STREAM && hs) checksum <= checksum + out_data;
`endif
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: directed vector table plus hand-written corner sequences for regfile_dump_reader.
module tb_regfile_dump_reader;
  localparam int RW = 5;
  localparam int DW = 32;
  typedef struct {
    logic [RW-1:0] first;
    logic [RW-1:0] last;
    int n;
    logic [3:0] rdy;
    logic [7:0][DW-1:0] dat;
    logic [7:0][RW-1:0] num;
    logic [DW-1:0] sum;
  } vec_t;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, out_ready = 0;
  logic [RW-1:0] first_reg = 0, last_reg = 0, rf_rd_num, out_num;
  logic [DW-1:0] rf_rd_data, out_data;
  logic out_valid, out_last, busy, done;
  logic [DW-1:0] rf [32];
  vec_t v [4];
  int checks = 0, fails = 0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif
  always #5 clk = ~clk;
  assign rf_rd_data = rf[rf_rd_num];
  regfile_dump_reader #(.REG_NUM_WIDTH(RW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .first_reg(first_reg), .last_reg(last_reg),
    .abort(abort), .rf_rd_num(rf_rd_num), .rf_rd_data(rf_rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_num(out_num), .out_last(out_last),
    .busy(busy), .done(done)
`ifdef REGFILE_DUMP_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic run_vec(input vec_t t);
    int w, cyc;
    logic held, hl;
    logic [DW-1:0] hd;
    logic [RW-1:0] hn;
    @(negedge clk);
    first_reg = t.first; last_reg = t.last; start = 1;
    @(negedge clk);
    start = 0;
    chk("fetch_busy", busy, 1);
    chk("fetch_valid", out_valid, 0);
    @(negedge clk);
    chk("latency_valid", out_valid, 1);
    w = 0; cyc = 0; held = 0;
    while (w < t.n && cyc < 200) begin
      if (held) begin
        chk("hold_data", out_data, hd);
        chk("hold_num", out_num, hn);
        chk("hold_last", out_last, hl);
      end
      out_ready = t.rdy[cyc % 4];
      if (out_valid && out_ready) begin
        chk("word_data", out_data, t.dat[w]);
        chk("word_num", out_num, t.num[w]);
        chk("word_last", out_last, w == t.n - 1);
        w++;
      end
      held = out_valid && !out_ready;
      hd = out_data; hn = out_num; hl = out_last;
      cyc++;
      @(negedge clk);
    end
    chk("word_count", w, t.n);
    out_ready = 0;
    chk("done_pulse", done, 1);
    chk("valid_after_last", out_valid, 0);
    chk("busy_after_last", busy, 0);
`ifdef REGFILE_DUMP_CHECKSUM_EN
    chk("checksum_done", checksum, t.sum);
`endif
    @(negedge clk);
    chk("done_one_cycle", done, 0);
`ifdef REGFILE_DUMP_CHECKSUM_EN
    chk("checksum_stable", checksum, t.sum);
`endif
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 0;
    for (int i = 0; i < 8; i++) rf[i] = 15 - i;
    rf[30] = 32'hAA; rf[31] = 32'hBB;
    for (int k = 0; k < 2; k++) begin
      v[k].first = 0; v[k].last = 7; v[k].n = 8; v[k].sum = 92;
      v[k].rdy = k == 0 ? 4'b1111 : 4'b1001;
      for (int i = 0; i < 8; i++) begin
        v[k].dat[i] = 15 - i;
        v[k].num[i] = i[RW-1:0];
      end
    end
    v[2].first = 30; v[2].last = 1; v[2].n = 4; v[2].rdy = 4'b1111; v[2].sum = 386;
    v[2].dat = '0; v[2].num = '0;
    v[2].dat[0] = 32'hAA; v[2].dat[1] = 32'hBB; v[2].dat[2] = 15; v[2].dat[3] = 14;
    v[2].num[0] = 30; v[2].num[1] = 31; v[2].num[2] = 0; v[2].num[3] = 1;
    v[3].first = 5; v[3].last = 5; v[3].n = 1; v[3].rdy = 4'b1111; v[3].sum = 10;
    v[3].dat = '0; v[3].num = '0;
    v[3].dat[0] = 10; v[3].num[0] = 5;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_num", out_num, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_num", rf_rd_num, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 4; k++) run_vec(v[k]);
    // start held while busy must not relatch the range
    @(negedge clk);
    first_reg = 5; last_reg = 5; start = 1;
    @(negedge clk);
    first_reg = 0; last_reg = 7;
    @(negedge clk);
    start = 0;
    chk("ign_valid", out_valid, 1);
    chk("ign_num", out_num, 5);
    chk("ign_data", out_data, 10);
    chk("ign_last", out_last, 1);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("ign_done", done, 1);
    @(negedge clk);
    chk("ign_busy", busy, 0);
    chk("ign_valid_after", out_valid, 0);
    // abort beats start in IDLE
    start = 1; abort = 1; first_reg = 0; last_reg = 7;
    @(negedge clk);
    start = 0; abort = 0;
    chk("abort_start_busy", busy, 0);
    @(negedge clk);
    chk("abort_start_busy2", busy, 0);
    // write to an upcoming register while the current word is stalled
    start = 1;
    @(negedge clk);
    start = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid && out_num == 2) break;
      out_ready = 1;
      @(negedge clk);
    end
    out_ready = 0;
    rf[3] = 99;
    @(negedge clk);
    chk("snap_hold_num", out_num, 2);
    out_ready = 1;
    @(negedge clk);
    chk("snap_num", out_num, 3);
    chk("snap_data", out_data, 99);
    begin
      int c;
      for (c = 0; c < 20 && !done; c++) @(negedge clk);
      chk("snap_done_seen", done, 1);
    end
    out_ready = 0;
    rf[3] = 12;
    // abort after three accepted words
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid && out_num == 3) break;
      out_ready = 1;
      @(negedge clk);
    end
    chk("abort_pre_num", out_num, 3);
    abort = 1; out_ready = 1;
    @(negedge clk);
    abort = 0; out_ready = 0;
    chk("abort_valid", out_valid, 0);
    chk("abort_last", out_last, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
`ifdef REGFILE_DUMP_CHECKSUM_EN
    chk("abort_checksum", checksum, 0);
`endif
    @(negedge clk);
    chk("abort_done2", done, 0);
    chk("abort_valid2", out_valid, 0);
    // asynchronous reset in the middle of a dump
    start = 1;
    @(negedge clk);
    start = 0; out_ready = 1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_num", out_num, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rd_num", rf_rd_num, 0);
    out_ready = 0;
    @(negedge clk);
    rst_n = 1;
    run_vec(v[0]);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Read-side sequencer for the register file.
- On a start pulse it walks a register range through one combinational read port (rd_num → rd_data, same cycle), and streams each value out over a valid/ready interface.
- Counterpart to the stimulus/writer side. Used by debug dump and by benches to read back architectural state without per-register driving.

Parameters:
- REG_NUM_WIDTH, 5, width of register number (32 registers).
- DATA_WIDTH, 32, width of register data.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- first_reg  in  REG_NUM_WIDTH  first register of range, latched on accepted start.
- last_reg  in  REG_NUM_WIDTH  last register of range, latched on accepted start.
- abort  in  1  synchronous cancel of a running dump.
- rf_rd_num  out  REG_NUM_WIDTH  read number to register file.
- rf_rd_data  in  DATA_WIDTH  read data from register file (combinational on rf_rd_num).
- out_valid  out  1  out_* word valid.
- out_ready  in  1  consumer accepts word when out_valid && out_ready.
- out_data  out  DATA_WIDTH  register value.
- out_num  out  REG_NUM_WIDTH  register number of out_data.
- out_last  out  1  word is the final register of the range.
- busy  out  1  high in FETCH/STREAM.
- done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE. out_valid=0, out_data=0, out_num=0, out_last=0, busy=0, done=0. Internal cur/last regs=0, rf_rd_num=0.
- IDLE:
  - rf_rd_num=0.
  - start=1: latch first_reg/last_reg, cur<=first_reg, go FETCH. busy=1 from next cycle.
- FETCH (exactly one cycle):
  - rf_rd_num=cur.
  - At the edge: out_data<=rf_rd_data, out_num<=cur, out_last<=(cur==last), out_valid<=1; go STREAM.
- STREAM:
  - rf_rd_num=cur+1, wrapping modulo 2^REG_NUM_WIDTH, i.e. prefetching the next register.
  - out_* held stable while out_valid && !out_ready.
  - Handshake with out_last=0: capture rf_rd_data into out_data, out_num<=cur+1, out_last<=(cur+1==last), cur<=cur+1. Gives back-to-back words at 1/cycle.
  - Handshake with out_last=1: out_valid<=0, done<=1 for one cycle, go IDLE.
- Latency: start edge → out_valid high 2 edges later (IDLE→FETCH→STREAM).
- Wrap-around: first_reg>last_reg walks first..max, 0..last. Example: 30→1 yields 30,31,0,1.
- first_reg==last_reg: single word with out_last=1.
- Snapshot rule: each word reflects the register file contents on the cycle it is captured, not on start. A write to an upcoming register before its capture edge is visible in the dump.
- start while busy: ignored, no latch, no effect.
- start and abort together in IDLE: abort wins, start ignored.
- abort in FETCH/STREAM: next edge out_valid=0, out_last=0, busy=0, state=IDLE, done not pulsed. A word pending on that edge is dropped even if out_ready=1.
- Reset mid-dump: immediate return to reset values; no done.
- Protocol rule: out_valid never deasserts without a handshake, except on abort or reset.

Optional Feature:
- Macro REGFILE_DUMP_CHECKSUM_EN.
- With it defined:
  - Extra output port checksum (out, DATA_WIDTH).
  - Accumulator cleared to 0 on accepted start.
  - On each handshake: acc<=acc+out_data, modulo 2^DATA_WIDTH.
  - checksum=acc, stable from the done pulse until the next accepted start.
  - Reset and abort clear acc to 0.
- Without it: no checksum port, no accumulator logic.

Test Plan:
- Reg file preloaded $0..$7=15,14,13,12,11,10,9,8; start with first=0, last=7, out_ready=1 → out_valid 2 cycles after start, then 8 consecutive words 15..8 with out_num 0..7, out_last only on num 7, done 1 cycle after; with checksum: 92.
- Same dump with out_ready toggling 1,0,0,1,... → each word held stable while not ready; sequence unchanged, no duplicates or drops.
- first=30, last=1 with $30=0xAA, $31=0xBB, $0=15, $1=14 → words 0xAA,0xBB,15,14, out_num 30,31,0,1; out_last on 1.
- first=last=5 ($5=10) → single word 10, out_last=1, done pulse; start asserted during busy ignored.
- Write $3=99 while $2 is held unaccepted in a 0..7 dump → $3 word reads 99.
- Abort after 3 words accepted → out_valid low next cycle, busy=0, no done, checksum=0. rst_n low mid-dump → all outputs 0 immediately; a fresh start afterwards dumps normally.
